// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-bus arbiter between the
// icache fill path and the dcache path.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARBIDLE = 2'd0,
        ARBADDR = 2'd1,
        ARBDATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNIC = 1'b0,
        OWNDC = 1'b1
    } owner_e;

    // Number of byte-offset address bits covered by one cache line of 64-bit beats.
    function automatic int line_lsb(input int beats);
        return $clog2(beats * 8);
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester and bus-side signal bundle of mem_arb; master is the arbiter,
// slave is the requester/bus environment.
interface mem_arb_if #(
    parameter int AW = 32
);
    logic          icreq;
    logic [AW-1:0] icaddr;
    logic          dcreq;
    logic [AW-1:0] dcaddr;
    logic          dcwr;
    logic          dcburst;
    logic [63:0]   dcwdata;
    logic          icgnt;
    logic          dcgnt;
    logic [63:0]   rdata;
    logic          icrvalid;
    logic          dcrvalid;
    logic          dcwready;
    logic          icdone;
    logic          dcdone;
    logic          icerr;
    logic          dcerr;
    logic          busreq;
    logic [AW-1:0] busaddr;
    logic          buswr;
    logic          busburst;
    logic          busack;
    logic [63:0]   buswdata;
    logic          buswvalid;
    logic          buswready;
    logic [63:0]   busrdata;
    logic          busrvalid;
    logic          buserr;

    modport master (
        input  icreq, icaddr, dcreq, dcaddr, dcwr, dcburst, dcwdata,
        input  busack, buswready, busrdata, busrvalid, buserr,
        output icgnt, dcgnt, rdata, icrvalid, dcrvalid, dcwready,
        output icdone, dcdone, icerr, dcerr,
        output busreq, busaddr, buswr, busburst, buswdata, buswvalid
    );

    modport slave (
        output icreq, icaddr, dcreq, dcaddr, dcwr, dcburst, dcwdata,
        output busack, buswready, busrdata, busrvalid, buserr,
        input  icgnt, dcgnt, rdata, icrvalid, dcrvalid, dcwready,
        input  icdone, dcdone, icerr, dcerr,
        input  busreq, busaddr, buswr, busburst, buswdata, buswvalid
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational owner select for mem_arb. MEM_ARB_RR_EN selects round-robin
// on ties; otherwise the dcache always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   icreq,
    input  logic   dcreq,
    input  owner_e last_owner,
    output owner_e owner
);

`ifdef MEM_ARB_RR_EN
    // Tie goes to whoever did not own the bus last.
    always_comb begin
        owner = OWNIC;
        if (icreq && dcreq) begin
            owner = (last_owner == OWNIC) ? OWNDC : OWNIC;
        end else if (dcreq) begin
            owner = OWNDC;
        end else begin
            owner = OWNIC;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{icreq, last_owner};

    // Fixed priority: dcache always wins.
    always_comb begin
        owner = OWNIC;
        if (dcreq) begin
            owner = OWNDC;
        end else begin
            owner = OWNIC;
        end
    end
`endif

endmodule

// File: rtl/mem_arb.sv
// External memory bus arbiter: one owner per transaction, address/data beat
// sequencing and response routing. MEM_ARB_RR_EN enables round-robin ties.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int LINEBEATS = 4,
    parameter int AW        = 32
) (
    input logic       clk,
    input logic       reset,
    mem_arb_if.master bus
);

    localparam int            CW        = $clog2(LINEBEATS) + 1;
    localparam int            LSB       = line_lsb(LINEBEATS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(LINEBEATS - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] LINE_MASK = {AW{1'b1}} << LSB;

    arb_state_e    state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          icgnt_r, icgnt_s;
    logic          dcgnt_r, dcgnt_s;
    logic          busreq_r, busreq_s;
    logic [AW-1:0] busaddr_r, busaddr_s;
    logic          buswr_r, buswr_s;
    logic          busburst_r, busburst_s;
    owner_e        last_r, last_s;
    owner_e        owner_s;
    logic          beat_s;
    logic          last_beat_s;
    logic          done_s;
    logic          active_s;

    mem_arb_pick u_pick (
        .icreq      (bus.icreq),
        .dcreq      (bus.dcreq),
        .last_owner (last_r),
        .owner      (owner_s)
    );

    // Next-state, grant/address capture and beat counting.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        icgnt_s     = icgnt_r;
        dcgnt_s     = dcgnt_r;
        busreq_s    = busreq_r;
        busaddr_s   = busaddr_r;
        buswr_s     = buswr_r;
        busburst_s  = busburst_r;
        last_s      = last_r;
        beat_s      = 1'b0;
        last_beat_s = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ARBIDLE: begin
                if (bus.icreq || bus.dcreq) begin
                    state_s  = ARBADDR;
                    busreq_s = 1'b1;
                    if (owner_s == OWNDC) begin
                        dcgnt_s    = 1'b1;
                        icgnt_s    = 1'b0;
                        busaddr_s  = bus.dcburst ? (bus.dcaddr & LINE_MASK) : bus.dcaddr;
                        buswr_s    = bus.dcwr;
                        busburst_s = bus.dcburst;
                    end else begin
                        icgnt_s    = 1'b1;
                        dcgnt_s    = 1'b0;
                        busaddr_s  = bus.icaddr & LINE_MASK;
                        buswr_s    = 1'b0;
                        busburst_s = 1'b1;
                    end
                end else begin
                    state_s = ARBIDLE;
                end
            end
            ARBADDR: begin
                // An error alongside busack cannot happen on this bus and is ignored.
                if (bus.busack) begin
                    state_s  = ARBDATA;
                    busreq_s = 1'b0;
                    cnt_s    = CNT_ZERO;
                end else begin
                    state_s = ARBADDR;
                end
            end
            ARBDATA: begin
                beat_s      = buswr_r ? bus.buswready : bus.busrvalid;
                last_beat_s = busburst_r ? (cnt_r == CNT_LAST) : (cnt_r == CNT_ZERO);
                if (beat_s && (last_beat_s || bus.buserr)) begin
                    done_s     = 1'b1;
                    state_s    = ARBIDLE;
                    cnt_s      = CNT_ZERO;
                    icgnt_s    = 1'b0;
                    dcgnt_s    = 1'b0;
                    busaddr_s  = {AW{1'b0}};
                    buswr_s    = 1'b0;
                    busburst_s = 1'b0;
                    last_s     = dcgnt_r ? OWNDC : OWNIC;
                end else if (beat_s) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s    = ARBIDLE;
                cnt_s      = CNT_ZERO;
                icgnt_s    = 1'b0;
                dcgnt_s    = 1'b0;
                busreq_s   = 1'b0;
                busaddr_s  = {AW{1'b0}};
                buswr_s    = 1'b0;
                busburst_s = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset aborts any transaction silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ARBIDLE;
            cnt_r      <= CNT_ZERO;
            icgnt_r    <= 1'b0;
            dcgnt_r    <= 1'b0;
            busreq_r   <= 1'b0;
            busaddr_r  <= {AW{1'b0}};
            buswr_r    <= 1'b0;
            busburst_r <= 1'b0;
            last_r     <= OWNIC;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            icgnt_r    <= icgnt_s;
            dcgnt_r    <= dcgnt_s;
            busreq_r   <= busreq_s;
            busaddr_r  <= busaddr_s;
            buswr_r    <= buswr_s;
            busburst_r <= busburst_s;
            last_r     <= last_s;
        end
    end

    // Data-phase routing follows the bus handshakes in the same cycle.
    assign active_s      = (state_r == ARBDATA) && !reset;
    assign bus.icrvalid  = active_s && !buswr_r && icgnt_r && bus.busrvalid;
    assign bus.dcrvalid  = active_s && !buswr_r && dcgnt_r && bus.busrvalid;
    assign bus.rdata     = (bus.icrvalid || bus.dcrvalid) ? bus.busrdata : 64'd0;
    assign bus.buswvalid = active_s && buswr_r;
    assign bus.dcwready  = bus.buswvalid && bus.buswready;
    assign bus.buswdata  = bus.buswvalid ? bus.dcwdata : 64'd0;
    assign bus.icdone    = active_s && done_s && icgnt_r;
    assign bus.dcdone    = active_s && done_s && dcgnt_r;
    assign bus.icerr     = bus.icdone && bus.buserr;
    assign bus.dcerr     = bus.dcdone && bus.buserr;

    assign bus.icgnt    = icgnt_r;
    assign bus.dcgnt    = dcgnt_r;
    assign bus.busreq   = busreq_r;
    assign bus.busaddr  = busaddr_r;
    assign bus.buswr    = buswr_r;
    assign bus.busburst = busburst_r;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: per-cycle vector table plus hand-written
// sequences for reset abort, arbitration order and address-phase stall.
module tb_mem_arb;

    typedef struct packed {
        logic        icreq;
        logic [31:0] icaddr;
        logic        dcreq;
        logic [31:0] dcaddr;
        logic        dcwr;
        logic        dcburst;
        logic [63:0] dcwdata;
        logic        busack;
        logic        buswready;
        logic [63:0] busrdata;
        logic        busrvalid;
        logic        buserr;
    } in_t;

    typedef struct packed {
        logic        icgnt;
        logic        dcgnt;
        logic        busreq;
        logic [31:0] busaddr;
        logic        buswr;
        logic        busburst;
        logic        icrvalid;
        logic        dcrvalid;
        logic [63:0] rdata;
        logic        dcwready;
        logic        buswvalid;
        logic [63:0] buswdata;
        logic        icdone;
        logic        dcdone;
        logic        icerr;
        logic        dcerr;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    localparam logic        N   = 1'b0;
    localparam logic        Y   = 1'b1;
    localparam logic [31:0] Z32 = 32'd0;
    localparam logic [63:0] Z64 = 64'd0;

    logic clk;
    logic reset;
    int   ncmp;
    int   nbad;
    int   n;
    int   m;
    vec_t tbl[$];
    logic [1:0] exp_own [4];

    mem_arb_if #(.AW(32)) bif ();

    mem_arb #(.LINEBEATS(4), .AW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t ib(input logic icreq, input logic [31:0] icaddr, input logic dcreq,
                               input logic [31:0] dcaddr, input logic dcwr, input logic dcburst,
                               input logic [63:0] dcwdata, input logic busack, input logic buswready,
                               input logic [63:0] busrdata, input logic busrvalid, input logic buserr);
        return {icreq, icaddr, dcreq, dcaddr, dcwr, dcburst, dcwdata, busack, buswready, busrdata, busrvalid, buserr};
    endfunction

    function automatic out_t eo(input logic ig, input logic dg, input logic br, input logic [31:0] ba,
                                input logic bw, input logic bb, input logic icv, input logic dcv,
                                input logic [63:0] rd, input logic wr, input logic wv, input logic [63:0] wd,
                                input logic id, input logic dd, input logic ie, input logic de);
        return {ig, dg, br, ba, bw, bb, icv, dcv, rd, wr, wv, wd, id, dd, ie, de};
    endfunction

    function automatic out_t sample();
        return {bif.icgnt, bif.dcgnt, bif.busreq, bif.busaddr, bif.buswr, bif.busburst,
                bif.icrvalid, bif.dcrvalid, bif.rdata, bif.dcwready, bif.buswvalid, bif.buswdata,
                bif.icdone, bif.dcdone, bif.icerr, bif.dcerr};
    endfunction

    task automatic drive(input in_t x);
        bif.icreq     = x.icreq;
        bif.icaddr    = x.icaddr;
        bif.dcreq     = x.dcreq;
        bif.dcaddr    = x.dcaddr;
        bif.dcwr      = x.dcwr;
        bif.dcburst   = x.dcburst;
        bif.dcwdata   = x.dcwdata;
        bif.busack    = x.busack;
        bif.buswready = x.buswready;
        bif.busrdata  = x.busrdata;
        bif.busrvalid = x.busrvalid;
        bif.buserr    = x.buserr;
    endtask

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input in_t a, input out_t b);
        vec_t v;
        v.i = a;
        v.o = b;
        tbl.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ncmp = 0;
        nbad = 0;
`ifdef MEM_ARB_RR_EN
        exp_own[0] = 2'b01; exp_own[1] = 2'b10; exp_own[2] = 2'b01; exp_own[3] = 2'b10;
`else
        exp_own[0] = 2'b01; exp_own[1] = 2'b01; exp_own[2] = 2'b01; exp_own[3] = 2'b01;
`endif

        // icache burst fill from 0x1234, aligned to 0x1220
        add(ib(Y,32'h1234,N,Z32,N,N,Z64, N,N,Z64,N,N), eo(N,N,N,Z32,N,N, N,N,Z64,N,N,Z64,N,N,N,N));
        add(ib(Y,32'h1234,N,Z32,N,N,Z64, Y,N,Z64,N,N), eo(Y,N,Y,32'h1220,N,Y, N,N,Z64,N,N,Z64,N,N,N,N));
        add(ib(Y,32'h1234,N,Z32,N,N,Z64, N,N,64'hA0,Y,N), eo(Y,N,N,32'h1220,N,Y, Y,N,64'hA0,N,N,Z64,N,N,N,N));
        add(ib(Y,32'h1234,N,Z32,N,N,Z64, N,N,64'hA1,Y,N), eo(Y,N,N,32'h1220,N,Y, Y,N,64'hA1,N,N,Z64,N,N,N,N));
        add(ib(Y,32'h1234,N,Z32,N,N,Z64, N,N,64'hA2,Y,N), eo(Y,N,N,32'h1220,N,Y, Y,N,64'hA2,N,N,Z64,N,N,N,N));
        add(ib(Y,32'h1234,N,Z32,N,N,Z64, N,N,64'hA3,Y,N), eo(Y,N,N,32'h1220,N,Y, Y,N,64'hA3,N,N,Z64,Y,N,N,N));
        add(ib(N,Z32,N,Z32,N,N,Z64, N,N,Z64,N,N), eo(N,N,N,Z32,N,N, N,N,Z64,N,N,Z64,N,N,N,N));
        // simultaneous requests: dc single write first, then ic after one idle cycle
        add(ib(Y,32'h40,Y,32'h4004,Y,N,64'hDEADBEEF, N,N,Z64,N,N), eo(N,N,N,Z32,N,N, N,N,Z64,N,N,Z64,N,N,N,N));
        add(ib(Y,32'h40,Y,32'h4004,Y,N,64'hDEADBEEF, Y,N,Z64,N,N), eo(N,Y,Y,32'h4004,Y,N, N,N,Z64,N,N,Z64,N,N,N,N));
        add(ib(Y,32'h40,Y,32'h4004,Y,N,64'hDEADBEEF, N,N,Z64,N,N), eo(N,Y,N,32'h4004,Y,N, N,N,Z64,N,Y,64'hDEADBEEF,N,N,N,N));
        add(ib(Y,32'h40,Y,32'h4004,Y,N,64'hDEADBEEF, N,Y,Z64,N,N), eo(N,Y,N,32'h4004,Y,N, N,N,Z64,Y,Y,64'hDEADBEEF,N,Y,N,N));
        add(ib(Y,32'h40,N,Z32,N,N,Z64, N,N,Z64,N,N), eo(N,N,N,Z32,N,N, N,N,Z64,N,N,Z64,N,N,N,N));
        add(ib(Y,32'h40,N,Z32,N,N,Z64, N,N,Z64,N,N), eo(Y,N,Y,32'h40,N,Y, N,N,Z64,N,N,Z64,N,N,N,N));
        add(ib(Y,32'h40,N,Z32,N,N,Z64, Y,N,Z64,N,N), eo(Y,N,Y,32'h40,N,Y, N,N,Z64,N,N,Z64,N,N,N,N));
        add(ib(Y,32'h40,N,Z32,N,N,Z64, N,N,64'hB0,Y,Y), eo(Y,N,N,32'h40,N,Y, Y,N,64'hB0,N,N,Z64,Y,N,Y,N));
        add(ib(N,Z32,N,Z32,N,N,Z64, N,N,Z64,N,N), eo(N,N,N,Z32,N,N, N,N,Z64,N,N,Z64,N,N,N,N));
        // dc burst read ending on an error with the 2nd beat; error during address phase ignored
        add(ib(N,Z32,Y,32'h8068,N,Y,Z64, N,N,Z64,N,N), eo(N,N,N,Z32,N,N, N,N,Z64,N,N,Z64,N,N,N,N));
        add(ib(N,Z32,Y,32'h8068,N,Y,Z64, Y,N,Z64,N,Y), eo(N,Y,Y,32'h8060,N,Y, N,N,Z64,N,N,Z64,N,N,N,N));
        add(ib(N,Z32,Y,32'h8068,N,Y,Z64, N,N,64'hC0,Y,N), eo(N,Y,N,32'h8060,N,Y, N,Y,64'hC0,N,N,Z64,N,N,N,N));
        add(ib(N,Z32,Y,32'h8068,N,Y,Z64, N,N,Z64,N,N), eo(N,Y,N,32'h8060,N,Y, N,N,Z64,N,N,Z64,N,N,N,N));
        add(ib(N,Z32,Y,32'h8068,N,Y,Z64, N,N,64'hC1,Y,Y), eo(N,Y,N,32'h8060,N,Y, N,Y,64'hC1,N,N,Z64,N,Y,N,Y));
        add(ib(N,Z32,N,Z32,N,N,Z64, N,N,64'hC2,Y,N), eo(N,N,N,Z32,N,N, N,N,Z64,N,N,Z64,N,N,N,N));

        drive(ib(N,Z32,N,Z32,N,N,Z64, N,N,Z64,N,N));
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_state", 192'(sample()), 192'd0);
        reset = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            drive(tbl[k].i);
            #1;
            chk($sformatf("vec%0d", k), 192'(sample()), 192'(tbl[k].o));
        end

        // reset during beat 2 of a dc burst read
        @(negedge clk); drive(ib(N,Z32,Y,32'h100,N,Y,Z64, N,N,Z64,N,N));
        @(negedge clk); drive(ib(N,Z32,Y,32'h100,N,Y,Z64, Y,N,Z64,N,N));
        @(negedge clk); drive(ib(N,Z32,Y,32'h100,N,Y,Z64, N,N,64'h1,Y,N));
        @(negedge clk); drive(ib(N,Z32,Y,32'h100,N,Y,Z64, N,N,64'h2,Y,N));
        @(negedge clk); drive(ib(N,Z32,Y,32'h100,N,Y,Z64, N,N,64'h3,Y,Y));
        reset = 1'b1;
        #1;
        chk("rst_no_done", 192'({bif.dcdone, bif.dcerr}), 192'd0);
        @(negedge clk); reset = 1'b0; drive(ib(N,Z32,N,Z32,N,N,Z64, N,N,64'h4,Y,N));
        #1;
        chk("rst_outputs", 192'(sample()), 192'd0);
        @(negedge clk); drive(ib(N,Z32,Y,32'h200,N,N,Z64, N,N,Z64,N,N));
        @(negedge clk); #1;
        chk("rst_regrant", 192'({bif.icgnt, bif.dcgnt, bif.busreq, bif.busaddr}), 192'({N, Y, Y, 32'h200}));
        bif.busack = 1'b1;
        @(negedge clk); bif.busack = 1'b0; bif.busrvalid = 1'b1; bif.busrdata = 64'h77;
        #1;
        chk("rst_regrant_done", 192'({bif.dcrvalid, bif.rdata, bif.dcdone}), 192'({Y, 64'h77, Y}));
        @(negedge clk); drive(ib(N,Z32,N,Z32,N,N,Z64, N,N,Z64,N,N));

        // arbitration with both requesters holding requests continuously
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; drive(ib(Y,32'h300,Y,32'h400,N,N,Z64, N,N,Z64,N,N));
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (!(bif.icgnt || bif.dcgnt) && n < 8) begin
                @(negedge clk); #1; n++;
            end
            chk($sformatf("arb%0d_owner", k), 192'({bif.icgnt, bif.dcgnt}), 192'(exp_own[k]));
            chk($sformatf("arb%0d_gap", k), 192'(n), 192'd1);
            bif.busack = 1'b1;
            @(negedge clk); bif.busack = 1'b0; bif.busrvalid = 1'b1; bif.busrdata = 64'(k);
            m = 0;
            #1;
            while (!(bif.icdone || bif.dcdone) && m < 8) begin
                @(negedge clk); #1; m++;
            end
            chk($sformatf("arb%0d_beats", k), 192'(m), (exp_own[k] == 2'b10) ? 192'd3 : 192'd0);
            @(negedge clk); bif.busrvalid = 1'b0;
        end
        drive(ib(N,Z32,N,Z32,N,N,Z64, N,N,Z64,N,N));
        @(negedge clk);

        // address phase held 10 cycles without busack
        @(negedge clk); drive(ib(N,Z32,Y,32'h1004,Y,N,64'h55, N,N,Z64,N,N));
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("stall%0d", k),
                192'({bif.busreq, bif.busaddr, bif.buswvalid, bif.dcwready, bif.dcrvalid, bif.icrvalid, bif.dcdone, bif.icdone}),
                192'({Y, 32'h1004, 6'b000000}));
            @(negedge clk);
        end
        bif.busack = 1'b1;
        @(negedge clk); bif.busack = 1'b0; bif.buswready = 1'b1;
        #1;
        chk("stall_done", 192'({bif.buswvalid, bif.buswdata, bif.dcwready, bif.dcdone, bif.dcerr}), 192'({Y, 64'h55, Y, Y, N}));
        @(negedge clk); drive(ib(N,Z32,N,Z32,N,N,Z64, N,N,Z64,N,N));
        #1;
        chk("final_idle", 192'(sample()), 192'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Shares the single external memory bus between the instruction-cache fill path and the data-cache path (line fill, line writeback, uncached single read/write).
- Sits between the cache/pipeline fill logic (icfill, dcfill, uncached loads/stores) and the bus interface unit.
- Grants one owner per transaction, sequences address and data beats, and routes read data, write handshakes and bus errors back to the owner.

Parameters:
- LINEBEATS, 4, 64-bit beats per cache-line burst; power of two, 2..8.
- AW, 32, physical address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- icreq  in  1  icache line-fill request, held until icdone
- icaddr  in  AW  icache fill physical address
- dcreq  in  1  dcache request, held until dcdone
- dcaddr  in  AW  dcache physical address
- dcwr  in  1  1=write, 0=read; stable while dcreq
- dcburst  in  1  1=line burst, 0=single beat; stable while dcreq
- dcwdata  in  64  write beat data
- icgnt  out  1  icache owns bus
- dcgnt  out  1  dcache owns bus
- rdata  out  64  read beat data, shared by both owners
- icrvalid  out  1  rdata valid for icache
- dcrvalid  out  1  rdata valid for dcache
- dcwready  out  1  current dcwdata beat consumed
- icdone  out  1  one-cycle pulse, transaction finished
- dcdone  out  1  one-cycle pulse, transaction finished
- icerr  out  1  bus error; coincident with icdone
- dcerr  out  1  bus error; coincident with dcdone
- busreq  out  1  address phase valid
- busaddr  out  AW  transaction address
- buswr  out  1  write transaction
- busburst  out  1  line burst
- busack  in  1  address accepted
- buswdata  out  64  equals dcwdata
- buswvalid  out  1  write beat valid
- buswready  in  1  write beat accepted
- busrdata  in  64  read beat data
- busrvalid  in  1  read beat valid
- buserr  in  1  bus error on current beat

Behaviour:
- Reset: state IDLE, beat count 0. All outputs 0, including busaddr. Reset mid-transaction aborts it: no done/err pulse, busreq drops the next cycle. Requesters see their grant fall.
- FSM states: IDLE, ADDR, DATA.
- IDLE: pick an owner if any req is high (dc over ic).
  - Register grant, busaddr, buswr, busburst; go to ADDR.
  - busreq is high in the cycle after the request is seen (one-cycle latency).
- Address fields for icache: buswr=0, busburst=1.
- Address fields for dcache: dcwr, dcburst as given.
- Burst address: low log2(LINEBEATS*8) bits forced to 0 (line aligned, no critical-word-first). Single-beat address is passed unmodified.
- ADDR: busreq held with stable fields until busack, then go to DATA with beat count 0. busack with buserr in ADDR: not allowed by bus, ignored.
- DATA, read: on each busrvalid, rdata<=busrdata combinationally, owner's rvalid=1, count+1.
- DATA, write (dc only): buswvalid=1 and dcwready=buswready; count+1 on buswready.
- Last beat is count == LINEBEATS-1 for a burst and count 0 for a single beat. On the last beat's handshake:
  - done pulse is asserted in that same cycle;
  - grant drops the next cycle;
  - state goes to IDLE.
- buserr with a beat handshake in DATA ends the transaction on that beat: done=1, err=1, that beat's rvalid still asserted. Remaining beats are not requested.
- The count never exceeds LINEBEATS-1; the counter width is log2(LINEBEATS)+1 to avoid wrap.
- Back-to-back: there is always one IDLE cycle between transactions. A requester holding req through its done cycle is re-arbitrated in that IDLE cycle.
- Requester dropping req while granted is illegal. The arbiter ignores it and completes the transaction.
- Grant is stable from IDLE exit to done. A request arriving mid-transaction waits.
- icgnt and dcgnt are never both 1.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin. A 1-bit last-owner register is updated at each done. When both request in IDLE, the requester that was not last owner wins. The register resets to "ic was last", so dc wins the first tie.
- MEM_ARB_RR_EN undefined: fixed priority, dc always wins ties. An icache starved by continuous dc traffic is accepted.

Decomposition:
- cpu.vh constants: ARBIDLE=0, ARBADDR=1, ARBDATA=2; owner ids OWNIC=0, OWNDC=1.
- One natural sub-module, mem_arb_pick:
  - combinational owner select from icreq, dcreq and the last-owner bit;
  - holds the MEM_ARB_RR_EN difference.
- FSM, counter and routing stay in mem_arb.

Test Plan:
- icreq=1, icaddr=0x00001234, LINEBEATS=4: busaddr=0x00001220 and busburst=1 one cycle later. busack, then 4 busrvalid beats with data 0xA0..0xA3 → icrvalid on each beat, icdone on the 4th beat, icgnt=0 the next cycle.
- icreq and dcreq rise in the same cycle, dcwr=1, dcburst=0:
  - dcgnt first;
  - single buswvalid beat, buswdata=dcwdata=0xDEADBEEF, dcdone when buswready;
  - one IDLE cycle, then icgnt.
- Burst read, buserr with the 2nd busrvalid → dcrvalid twice; dcdone=dcerr=1 on the 2nd beat; no 3rd beat consumed; state back to IDLE.
- reset=1 while in DATA at beat 2 → next cycle all outputs 0, no done pulse. New dcreq is granted normally after reset falls.
- With MEM_ARB_RR_EN, both requesters continuously requesting → grants alternate dc, ic, dc, ic. Without the macro, dc is granted every time.
- busack held 0 for 10 cycles → busreq and busaddr stable for all 10 cycles, no data-side outputs asserted.
